// File: rtl/horner_stream_sched_pkg.sv
// Shared types and defaults for the Horner stream sequencer: FSM state encoding,
// default geometry and a width helper for counters that must hold 0..max inclusive.
package horner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  localparam int PIPE_LAT_DEF   = 46;
  localparam int MAT_BEATS_DEF  = 3;
  localparam int LANES          = 4;
  localparam int FIFO_DEPTH_DEF = 64;
  localparam int CNT_WIDTH_DEF  = 16;

  // Bits needed to represent every value from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/horner_stream_sched_if.sv
// AXIS input handshake, datapath strobes and status of the Horner stream sequencer.
// The sequencer uses the slave view; the surrounding stream/datapath uses master.
interface horner_stream_sched_if #(
  parameter int CNT_WIDTH = 16
);

  logic                 s_tvalid;
  logic                 s_tlast;
  logic                 s_tready;
  logic                 load_matrix;
  logic [1:0]           mat_beat_idx;
  logic                 stream_en;
  logic                 dp_valid;
  logic                 dp_last;
  logic                 fifo_pop;
  logic                 pkt_done;
  logic                 hdr_err;
  logic                 err_clr;
  logic [CNT_WIDTH-1:0] beat_cnt;

  modport slave (
    input  s_tvalid, s_tlast, fifo_pop, err_clr,
    output s_tready, load_matrix, mat_beat_idx, stream_en,
           dp_valid, dp_last, pkt_done, hdr_err, beat_cnt
  );

  modport master (
    output s_tvalid, s_tlast, fifo_pop, err_clr,
    input  s_tready, load_matrix, mat_beat_idx, stream_en,
           dp_valid, dp_last, pkt_done, hdr_err, beat_cnt
  );

endinterface

// File: rtl/horner_credit_cnt.sv
// Saturating up/down counter with zero flag: counts up to MAX, never below zero,
// and holds when increment and decrement arrive together.
module horner_credit_cnt #(
  parameter int MAX  = 64,
  parameter int INIT = 0,
  parameter int W    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic [W-1:0] r_count;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= INIT_V;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (r_count != MAX_V) r_count <= r_count + W'(1);
        2'b01:   if (r_count != '0)    r_count <= r_count - W'(1);
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/horner_stream_sched.sv
// Control sequencer for the stream datapath: splits each packet into matrix header
// and vector beats, tracks the fixed-latency pipeline and gates input on FIFO credit.
module horner_stream_sched
  import horner_pkg::*;
#(
  parameter int PIPE_LAT   = PIPE_LAT_DEF,
  parameter int MAT_BEATS  = MAT_BEATS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  horner_stream_sched_if.slave  bus
);

  localparam int CRED_W = cnt_w(FIFO_DEPTH);
  localparam int INFL_W = cnt_w(PIPE_LAT);

  state_e               r_state, w_next_state;
  logic [1:0]           r_hidx;
  logic                 r_hdr_err;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [PIPE_LAT-1:0]  r_vld_sr, r_lst_sr;

  logic                 w_tready, w_load, w_stream_en, w_pkt_done;
  logic [1:0]           w_idx;
  logic                 w_last_hdr, w_hdr_err_set;
  logic [CRED_W-1:0]    w_credit;
  logic                 w_credit_zero;
  logic [INFL_W-1:0]    w_inflight;
  logic                 w_inflight_zero;
  logic                 w_unused_cnt;

  assign w_last_hdr    = (r_state == ST_IDLE) ? (MAT_BEATS == 1)
                                              : (r_hidx == 2'(MAT_BEATS - 1));
  assign w_hdr_err_set = w_load & bus.s_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_load) begin
          if (bus.s_tlast)     w_next_state = ST_IDLE;
          else if (w_last_hdr) w_next_state = ST_STREAM;
          else                 w_next_state = ST_LOAD;
        end
      end
      ST_STREAM: if (w_stream_en && bus.s_tlast) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_pkt_done)                 w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Strobes are qualified by s_tvalid per state rather than by s_tready, which keeps
  // the ready/accept path free of a combinational loop.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    w_tready    = 1'b0;
    w_load      = 1'b0;
    w_idx       = 2'd0;
    w_stream_en = 1'b0;
    w_pkt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tready = 1'b1;
        w_load   = bus.s_tvalid;
      end
      ST_LOAD: begin
        w_tready = 1'b1;
        w_load   = bus.s_tvalid;
        w_idx    = r_hidx;
      end
      ST_STREAM: begin
        w_tready    = !w_credit_zero;
        w_stream_en = bus.s_tvalid & !w_credit_zero;
      end
      ST_DRAIN: w_pkt_done = r_vld_sr[PIPE_LAT-1] & r_lst_sr[PIPE_LAT-1];
      default: ;
    endcase
  end

  // NOTE: the tracking shift registers are plain flops and are reset, so a reset
  // mid-packet discards every in-flight result instead of replaying stale ones.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hidx     <= 2'd0;
      r_hdr_err  <= 1'b0;
      r_beat_cnt <= '0;
      r_vld_sr   <= '0;
      r_lst_sr   <= '0;
    end else begin
      if (w_load) r_hidx <= (w_hdr_err_set || w_last_hdr) ? 2'd0 : r_hidx + 2'd1;
      if (w_hdr_err_set)    r_hdr_err <= 1'b1;
      else if (bus.err_clr) r_hdr_err <= 1'b0;
      if (w_pkt_done)       r_beat_cnt <= '0;
      else if (w_stream_en) r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], w_stream_en};
      r_lst_sr <= {r_lst_sr[PIPE_LAT-2:0], w_stream_en & bus.s_tlast};
    end
  end

  // Credit = free output FIFO slots not yet claimed by beats inside the pipeline.
  horner_credit_cnt #(.MAX(FIFO_DEPTH), .INIT(FIFO_DEPTH), .W(CRED_W)) u_credit (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_inc   (bus.fifo_pop),
    .i_dec   (w_stream_en),
    .o_count (w_credit),
    .o_zero  (w_credit_zero)
  );

  horner_credit_cnt #(.MAX(PIPE_LAT), .INIT(0), .W(INFL_W)) u_inflight (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_inc   (w_stream_en),
    .i_dec   (r_vld_sr[PIPE_LAT-1]),
    .o_count (w_inflight),
    .o_zero  (w_inflight_zero)
  );

  // Counter values are kept for debug visibility only.
  assign w_unused_cnt = ^{w_credit, w_inflight, w_inflight_zero};

  assign bus.s_tready     = w_tready;
  assign bus.load_matrix  = w_load;
  assign bus.mat_beat_idx = w_idx;
  assign bus.stream_en    = w_stream_en;
  assign bus.dp_valid     = r_vld_sr[PIPE_LAT-1];
  assign bus.dp_last      = r_lst_sr[PIPE_LAT-1];
  assign bus.pkt_done     = w_pkt_done;
  assign bus.hdr_err      = r_hdr_err;
  assign bus.beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_horner_stream_sched.sv
// Self-checking bench: directed packets with a result scoreboard keyed on the
// cycle each accepted vector beat should emerge from the pipeline.
module tb_horner_stream_sched;

  localparam int PIPE_LAT  = 46;
  localparam int MAT_BEATS = 3;
  localparam int DEPTH     = 4;
  localparam int CW        = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  horner_stream_sched_if #(.CNT_WIDTH(CW)) bus ();

  horner_stream_sched #(
    .PIPE_LAT   (PIPE_LAT),
    .MAT_BEATS  (MAT_BEATS),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_credit = DEPTH;
  bit   mon_ev, mon_el;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Result monitor: every dp_valid must match the scoreboard head due this cycle.
  always @(negedge clk) begin
    mon_ev = 1'b0;
    mon_el = 1'b0;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      mon_ev = 1'b1;
      mon_el = sb[0].last;
      void'(sb.pop_front());
    end
    if (mon_ev || bus.dp_valid || bus.pkt_done) begin
      check("dp_valid", bus.dp_valid, mon_ev);
      check("dp_last",  bus.dp_last,  mon_el);
      check("pkt_done", bus.pkt_done, mon_el);
    end
  end

  task automatic put(input bit v, input bit l, input bit p, input bit clr);
    bus.s_tvalid = v;
    bus.s_tlast  = l;
    bus.fifo_pop = p;
    bus.err_clr  = clr;
    @(negedge clk);
  endtask

  task automatic adv(input bit acc);
    int n;
    n = m_credit - int'(acc) + int'(bus.fifo_pop);
    m_credit = (n > DEPTH) ? DEPTH : n;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input bit p);
    for (int i = 0; i < MAT_BEATS; i++) begin
      put(1'b1, 1'b0, p, 1'b0);
      check("hdr_rdy",  bus.s_tready, 1);
      check("hdr_load", bus.load_matrix, 1);
      check("hdr_idx",  bus.mat_beat_idx, i);
      check("hdr_sen",  bus.stream_en, 0);
      adv(1'b0);
    end
  endtask

  // mode 0: pop every cycle; mode 1: sparse pops that starve and refill credit.
  task automatic stream_pkt(input int n, input bit send_last, input int mode);
    int sent;
    sent = 0;
    for (int k = 0; k < 40 && sent < n; k++) begin
      bit p, l, r;
      p = (mode == 0) ? 1'b1 : (k == 6 || k == 9 || k >= 10);
      l = send_last && (sent == n - 1);
      r = (m_credit != 0);
      put(1'b1, l, p, 1'b0);
      check("s_tready",  bus.s_tready, r);
      check("stream_en", bus.stream_en, r);
      check("no_load",   bus.load_matrix, 0);
      if (r) begin
        sb.push_back('{cyc + PIPE_LAT, l});
        sent++;
      end
      adv(r);
    end
    check("stream_sent", sent, n);
  endtask

  task automatic wait_drain(input bit p, input int exp_cnt, input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) begin
      put(1'b0, 1'b0, p, 1'b0);
      if (k == 0) begin
        check("drain_rdy", bus.s_tready, 0);
        check("drain_cnt", bus.beat_cnt, exp_cnt);
      end
      adv(1'b0);
    end
    check("drain_done", sb.size(), 0);
    put(1'b0, 1'b0, p, 1'b0);
    check("idle_rdy", bus.s_tready, 1);
    check("idle_cnt", bus.beat_cnt, 0);
    adv(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  bus.s_tready, 1);
    check({tag, "_load"}, bus.load_matrix, 0);
    check({tag, "_idx"},  bus.mat_beat_idx, 0);
    check({tag, "_sen"},  bus.stream_en, 0);
    check({tag, "_dpv"},  bus.dp_valid, 0);
    check({tag, "_dpl"},  bus.dp_last, 0);
    check({tag, "_done"}, bus.pkt_done, 0);
    check({tag, "_err"},  bus.hdr_err, 0);
    check({tag, "_cnt"},  bus.beat_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.fifo_pop = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3 header + 5 vector beats, pop tied high: results at +46 cycles.
    send_hdr(1'b1);
    stream_pkt(5, 1'b1, 0);
    wait_drain(1'b1, 5, PIPE_LAT + 8);

    // Credit starvation with a 4-entry FIFO and sparse pops, 10 vector beats.
    send_hdr(1'b0);
    stream_pkt(10, 1'b1, 1);
    wait_drain(1'b1, 10, PIPE_LAT + 8);

    // s_tlast on header beat 1 aborts the packet.
    put(1'b1, 1'b0, 1'b0, 1'b0);
    check("err_b0_idx", bus.mat_beat_idx, 0);
    adv(1'b0);
    put(1'b1, 1'b1, 1'b0, 1'b0);
    check("err_b1_load", bus.load_matrix, 1);
    check("err_b1_idx",  bus.mat_beat_idx, 1);
    check("err_pre",     bus.hdr_err, 0);
    adv(1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b1);
    check("err_set",  bus.hdr_err, 1);
    check("err_idle", bus.s_tready, 1);
    check("err_nsen", bus.stream_en, 0);
    adv(1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_clr", bus.hdr_err, 0);
    adv(1'b0);
    // Same-cycle set and clear: set wins.
    put(1'b1, 1'b1, 1'b0, 1'b1);
    check("prio_idx", bus.mat_beat_idx, 0);
    adv(1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b1);
    check("prio_set", bus.hdr_err, 1);
    adv(1'b0);
    put(1'b0, 1'b0, 1'b0, 1'b0);
    check("prio_clr", bus.hdr_err, 0);
    adv(1'b0);
    send_hdr(1'b1);
    stream_pkt(3, 1'b1, 0);
    wait_drain(1'b1, 3, PIPE_LAT + 8);

    // Back-to-back packets: next header is held off until pkt_done.
    send_hdr(1'b1);
    stream_pkt(2, 1'b1, 0);
    for (int k = 0; k < PIPE_LAT; k++) begin
      put(1'b1, 1'b0, 1'b1, 1'b0);
      check("b2b_hold_rdy",  bus.s_tready, 0);
      check("b2b_hold_load", bus.load_matrix, 0);
      adv(1'b0);
    end
    for (int i = 0; i < MAT_BEATS; i++) begin
      put(1'b1, 1'b0, 1'b1, 1'b0);
      check("b2b_load", bus.load_matrix, 1);
      check("b2b_idx",  bus.mat_beat_idx, i);
      if (i == 0) check("b2b_cnt0", bus.beat_cnt, 0);
      adv(1'b0);
    end
    stream_pkt(2, 1'b1, 0);
    wait_drain(1'b1, 2, PIPE_LAT + 8);

    // Asynchronous reset with 20 beats in flight.
    send_hdr(1'b1);
    stream_pkt(20, 1'b0, 0);
    check("pre_rst_cnt", bus.beat_cnt, 20);
    bus.s_tvalid = 1'b0;
    bus.fifo_pop = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    sb.delete();
    m_credit = DEPTH;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < PIPE_LAT + 4; k++) begin
      put(1'b0, 1'b0, 1'b0, 1'b0);
      adv(1'b0);
    end
    send_hdr(1'b0);
    stream_pkt(10, 1'b1, 1);
    wait_drain(1'b1, 10, PIPE_LAT + 8);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
